pipe_stage_queue: RTL and testbench

Parametrised elastic pipeline-stage queue. It replaces the fixed single-entry fd/ie/ew latches between pipeline stages with a DEPTH-entry, WIDTH-bit FIFO. The queue uses a valid/ready handshake on both sides and supports a synchronous flush for mispredictions. It sits between any producer/consumer stage pair, for example fetch→dispatch, so that upstream can run ahead while downstream stalls.

---
 rtl/pipe_stage_queue.sv | 102 ++++++++++
 tb/tb_pipe_stage_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_queue.sv
// Elastic DEPTH x WIDTH valid/ready queue placed between two pipeline stages, with synchronous flush.
// Define PIPE_STAGE_BYPASS_EN to let an empty queue pass in_data straight to the output.
module pipe_stage_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nrst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic full_s;
    logic empty_s;
    logic bypass_xfer;
    logic push_store;
    logic pop_mem;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == '0);

    assign count    = count_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign in_ready = !full_s;

`ifdef PIPE_STAGE_BYPASS_EN
    logic bypass_active;

    // nrst gates the bypass so the outputs still read as reset while nrst is low.
    assign bypass_active = empty_s & !flush & nrst;
    assign bypass_xfer   = bypass_active & in_valid & out_ready;
    assign out_valid     = bypass_active ? in_valid : !empty_s;
    assign out_data      = bypass_active ? in_data : mem_q[rptr_q];
`else
    assign bypass_xfer = 1'b0;
    assign out_valid   = !empty_s;
    assign out_data    = mem_q[rptr_q];
`endif

    // A bypassed transfer never touches storage, so it counts as neither push nor pop.
    assign push_store = in_valid & !full_s & !bypass_xfer;
    assign pop_mem    = !empty_s & out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_store) begin
                mem_d[wptr_q] = in_data;
                wptr_d        = wptr_q + PW'(1);
            end
            if (pop_mem) begin
                rptr_d = rptr_q + PW'(1);
            end
            unique case ({push_store, pop_mem})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_queue.sv
// Self-checking bench for pipe_stage_queue (DEPTH=4, WIDTH=16) against a queue-based reference model.
module tb_pipe_stage_queue;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;
    localparam int unsigned C = $clog2(D + 1);
`ifdef PIPE_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK;
    logic          nrst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [C-1:0]  count;
    logic          full;
    logic          empty;

    int n_cmp;
    int n_fail;
    logic [W-1:0] mq[$];

    pipe_stage_queue #(
        .WIDTH(W),
        .DEPTH(D)
    ) u_dut (
        .CLK      (CLK),
        .nrst     (nrst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive inputs and let combinational outputs settle (called just after a rising edge).
    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    function automatic logic exp_valid();
        if (mq.size() != 0) return 1'b1;
        return BYP && !flush && in_valid;
    endfunction

    function automatic logic [W-1:0] exp_data();
        if (mq.size() != 0) return mq[0];
        return in_data;
    endfunction

    // Advance the model by the transfer the current inputs imply, then clock the DUT.
    task automatic tick();
        int sz;
        sz = mq.size();
        if (flush) begin
            mq.delete();
        end else if (!(BYP && sz == 0 && in_valid && out_ready)) begin
            if (out_ready && sz > 0) void'(mq.pop_front());
            if (in_valid && sz < int'(D)) mq.push_back(in_data);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #20;
        mq.delete();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL reset_flags got full=%b empty=%b want 0/1", full, empty); end
        @(negedge CLK);
        nrst = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid_fill();
        drive(1'b1, 16'h000A, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h000B, 1'b0, 1'b0); tick();
        n_cmp++; if (count !== C'(2)) begin n_fail++; $display("FAIL midfill_count got %0d want 2", count); end
        drive(1'b0, '0, 1'b0, 1'b0);
        nrst = 1'b0;
        #1;
        mq.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midfill_rst_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL midfill_rst_count got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midfill_rst_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL midfill_rst_data got %h want 0", out_data); end
        @(negedge CLK);
        nrst = 1'b1;
        @(posedge CLK);
        #1;
        drive(1'b1, 16'h000C, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h000C) begin n_fail++; $display("FAIL midfill_first got v=%b d=%h want 1/000c", out_valid, out_data); end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0); tick();
        end
        drive(1'b1, 16'h0005, 1'b0, 1'b0);
        n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== C'(4)) begin n_fail++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d want 1/0/4", full, in_ready, count); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (count !== C'(4)) begin n_fail++; $display("FAIL fill_fifth_ignored got cnt=%0d want 4", count); end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin n_fail++; $display("FAIL drain_%0d got v=%b d=%h want 1/%h", i, out_valid, out_data, W'(i)); end
            tick();
        end
        n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got empty=%b v=%b want 1/0", empty, out_valid); end
    endtask

    task automatic test_wrap_stream();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            n_cmp++; if (count > C'(1)) begin n_fail++; $display("FAIL stream_count_%0d got %0d want <=1", i, count); end
            n_cmp++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL stream_valid_%0d got %b want %b", i, out_valid, exp_valid()); end
            if (i > 0 || BYP) begin
                n_cmp++; if (out_data !== (BYP ? W'(i) : W'(i - 1))) begin n_fail++; $display("FAIL stream_data_%0d got %h want %h", i, out_data, BYP ? W'(i) : W'(i - 1)); end
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        if (!BYP) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(9)) begin n_fail++; $display("FAIL stream_last got v=%b d=%h want 1/0009", out_valid, out_data); end
        end
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got %b want 1", empty); end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 16'h0021, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0022, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0023, 1'b1, 1'b0);
        n_cmp++; if (out_data !== 16'h0021) begin n_fail++; $display("FAIL pp_head got %h want 0021", out_data); end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (count !== C'(2)) begin n_fail++; $display("FAIL pp_count got %0d want 2", count); end
        n_cmp++; if (out_data !== 16'h0022) begin n_fail++; $display("FAIL pp_next got %h want 0022", out_data); end
        tick();
        n_cmp++; if (out_data !== 16'h0023 || count !== C'(1)) begin n_fail++; $display("FAIL pp_last got d=%h cnt=%0d want 0023/1", out_data, count); end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, W'(16'h0030 + i), 1'b0, 1'b0); tick();
        end
        drive(1'b1, 16'h000F, 1'b1, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0031) begin n_fail++; $display("FAIL flush_pre got v=%b d=%h want 1/0031", out_valid, out_data); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_post got cnt=%0d v=%b rdy=%b want 0/0/1", count, out_valid, in_ready); end
        drive(1'b1, 16'h0041, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0041 || count !== C'(1)) begin n_fail++; $display("FAIL flush_after_push got v=%b d=%h cnt=%0d want 1/0041/1", out_valid, out_data, count); end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 16'h0055, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== BYP) begin n_fail++; $display("FAIL bypass_valid got %b want %b", out_valid, BYP); end
        if (BYP) begin
            n_cmp++; if (out_data !== 16'h0055) begin n_fail++; $display("FAIL bypass_data got %h want 0055", out_data); end
        end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (count !== (BYP ? C'(0) : C'(1))) begin n_fail++; $display("FAIL bypass_count got %0d want %0d", count, BYP ? 0 : 1); end
        if (!BYP) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0055) begin n_fail++; $display("FAIL bypass_late got v=%b d=%h want 1/0055", out_valid, out_data); end
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            n_cmp++; if (count !== C'(mq.size())) begin n_fail++; $display("FAIL rnd_count_%0d got %0d want %0d", i, count, mq.size()); end
            n_cmp++; if (in_ready !== (mq.size() < int'(D))) begin n_fail++; $display("FAIL rnd_ready_%0d got %b", i, in_ready); end
            n_cmp++; if (full !== (mq.size() == int'(D)) || empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_flags_%0d got full=%b empty=%b size=%0d", i, full, empty, mq.size()); end
            n_cmp++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid_%0d got %b want %b", i, out_valid, exp_valid()); end
            if (exp_valid()) begin
                n_cmp++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data_%0d got %h want %h", i, out_data, exp_data()); end
            end
            tick();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_reset_mid_fill();
        test_fill_drain();
        test_wrap_stream();
        test_push_pop();
        test_flush();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
